// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Size codes, FSM states and the default DMEM base address.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    ERR,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lsu_if.sv
// CPU request/response and DMEM bus of the load/store unit.
// master = CPU plus memory environment, slave = the LSU itself.
interface dmem_lsu_if #(
  parameter int AW = 11
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic          dm_ena;
  logic          dm_we;
  logic          dm_re;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output dm_rdata,
    input  req_ready, resp_valid, resp_err,
    input  resp_rdata,
    input  dm_ena, dm_we, dm_re,
    input  dm_addr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  dm_rdata,
    output req_ready, resp_valid, resp_err,
    output resp_rdata,
    output dm_ena, dm_we, dm_re,
    output dm_addr, dm_wdata
  );

endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: load extract/extend and store merge.
// Purely combinational; one instance serves both paths.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_ld_word,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lsb,
  input  logic [31:0] i_st_old,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_word
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  assign w_bsh = {i_lsb, 3'b000};
  assign w_hsh = {i_lsb[1], 4'b0000};

  always_comb begin
    w_byte = 8'(i_ld_word >> w_bsh);
    w_half = 16'(i_ld_word >> w_hsh);
    o_ld_data = i_ld_word;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_ld_data = {{24{i_signed & w_byte[7]}},
                     w_byte};
      (i_size == SZ_HALF):
        o_ld_data = {{16{i_signed & w_half[15]}},
                     w_half};
      default:
        o_ld_data = i_ld_word;
    endcase
  end

  always_comb begin
    w_mask = '1;
    w_ins  = i_st_data;
    unique case (1'b1)
      (i_size == SZ_BYTE): begin
        w_mask = 32'h0000_00FF << w_bsh;
        w_ins  = {24'd0, i_st_data[7:0]} << w_bsh;
      end
      (i_size == SZ_HALF): begin
        w_mask = 32'h0000_FFFF << w_hsh;
        w_ins  = {16'd0, i_st_data[15:0]} << w_hsh;
      end
      default: ;
    endcase
    o_st_word = (i_st_old & ~w_mask)
              | (w_ins & w_mask);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the CPU and word-organised DMEM.
// Sub-word stores run as read-modify-write; all outputs registered.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          AW          = 11,
  parameter int          DEPTH_WORDS = 2048
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  state_t        r_state;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [1:0]    r_lsb;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          r_ready;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [31:0]   r_resp_rdata;
  logic          r_dm_ena;
  logic          r_dm_we;
  logic          r_dm_re;
  logic [AW-1:0] r_dm_addr;
  logic [31:0]   r_dm_wdata;

  logic          w_acc;
  logic [29:0]   w_widx;
  logic [AW-1:0] w_idx;
  logic          w_mis;
  logic          w_bad_sz;
  logic          w_low;
  logic          w_oor;
  logic          w_err;
  logic          w_sub_st;
  logic [31:0]   w_ld;
  logic [31:0]   w_merge;

  assign w_acc  = bus.req_valid & r_ready;
  // Index wraps mod 2^32; range uses unwrapped compare.
  assign w_widx = 30'((bus.req_addr - BASE_ADDR) >> 2);
  assign w_idx  = w_widx[AW-1:0];

  assign w_mis =
    ((bus.req_size == SZ_HALF) & bus.req_addr[0])
    | ((bus.req_size == SZ_WORD)
       & (bus.req_addr[1:0] != 2'b00));
  assign w_bad_sz = (bus.req_size == 2'b11);
  assign w_low    = (bus.req_addr < BASE_ADDR);
  assign w_oor    = (w_widx >= 30'(DEPTH_WORDS));
  assign w_err    = w_mis | w_bad_sz | w_low | w_oor;
  assign w_sub_st = (bus.req_size != SZ_WORD);

  lsu_lane u_lane (
    .i_ld_word (bus.dm_rdata),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_lsb     (r_lsb),
    .i_st_old  (bus.dm_rdata),
    .i_st_data (r_wdata),
    .o_ld_data (w_ld),
    .o_st_word (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_lsb        <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_dm_ena     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_re      <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_lsb    <= bus.req_addr[1:0];
            r_idx    <= w_idx;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_err;
            r_ready  <= 1'b0;
            if (w_err) begin
              r_state <= ERR;
            end else if (!bus.req_we) begin
              r_state   <= RD;
              r_dm_ena  <= 1'b1;
              r_dm_re   <= 1'b1;
              r_dm_addr <= w_idx;
            end else if (w_sub_st) begin
              r_state   <= RMW_RD;
              r_dm_ena  <= 1'b1;
              r_dm_re   <= 1'b1;
              r_dm_addr <= w_idx;
            end else begin
              r_state    <= WR;
              r_dm_ena   <= 1'b1;
              r_dm_we    <= 1'b1;
              r_dm_addr  <= w_idx;
              r_dm_wdata <= bus.req_wdata;
            end
          end
        end
        RD: begin
          r_state      <= RESP;
          r_dm_ena     <= 1'b0;
          r_dm_re      <= 1'b0;
          r_dm_addr    <= '0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_ld;
        end
        RMW_RD: begin
          r_state    <= WR;
          r_wdata    <= w_merge;
          r_dm_re    <= 1'b0;
          r_dm_we    <= 1'b1;
          r_dm_addr  <= r_idx;
          r_dm_wdata <= w_merge;
        end
        WR: begin
          r_state      <= RESP;
          r_dm_ena     <= 1'b0;
          r_dm_we      <= 1'b0;
          r_dm_addr    <= '0;
          r_dm_wdata   <= '0;
          r_resp_valid <= 1'b1;
        end
        ERR: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
        end
        RESP: begin
          r_state      <= IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.dm_ena     = r_dm_ena;
  assign bus.dm_we      = r_dm_we;
  assign bus.dm_re      = r_dm_re;
  assign bus.dm_addr    = r_dm_addr;
  assign bus.dm_wdata   = r_dm_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word-wide DMEM model.
// Expected values are hand-computed constants.
module tb_dmem_lsu;

  localparam int AW = 11;

  logic clk;
  logic rst;

  dmem_lsu_if #(.AW(AW)) bus ();

  dmem_lsu #(
    .BASE_ADDR   (32'h1001_0000),
    .AW          (AW),
    .DEPTH_WORDS (2048)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic        poke_en;
  logic [10:0] poke_addr;
  logic [31:0] poke_data;

  assign bus.dm_rdata = bus.dm_re
                      ? mem[bus.dm_addr] : 32'hzzzz_zzzz;

  int          n_tot = 0;
  int          n_bad = 0;
  int          resp_cnt = 0;
  int          acc_cnt = 0;
  int          ena_cnt = 0;
  int          re_cnt = 0;
  int          wr_cnt = 0;
  int          clash = 0;
  logic [10:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_addr] <= poke_data;
    else if (bus.dm_ena && bus.dm_we)
      mem[bus.dm_addr] <= bus.dm_wdata;
    if (bus.dm_we && bus.dm_re) clash <= clash + 1;
    if (bus.dm_ena) ena_cnt <= ena_cnt + 1;
    if (bus.dm_re) re_cnt <= re_cnt + 1;
    if (bus.dm_we) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= bus.dm_addr;
      last_wdata <= bus.dm_wdata;
    end
    if (bus.resp_valid) begin
      resp_cnt   <= resp_cnt + 1;
      last_rdata <= bus.resp_rdata;
    end
    if (bus.req_valid && bus.req_ready)
      acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [10:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic we,
                        input logic [1:0] sz,
                        input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output int lat,
                        output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    wait_ready("ready_to");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
        break;
      end
    end
    if (lat == 0) chk("resp_to", 32'd0, 32'd1);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          snap;
  int          snap2;

  initial begin
    rst            = 1'b1;
    poke_en        = 1'b0;
    poke_addr      = '0;
    poke_data      = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rv", 32'(bus.resp_valid), 32'd0);
    chk("rst_ena", 32'(bus.dm_ena), 32'd0);
    chk("rst_addr", 32'(bus.dm_addr), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;

    // word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0008,
           32'hDEAD_BEEF, lat, rd, er);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_waddr", 32'(last_waddr), 32'd2);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_mem", mem[2], 32'hDEAD_BEEF);
    snap = re_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0008,
           32'h0, lat, rd, er);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_re", 32'(re_cnt - snap), 32'd1);

    // sub-word stores by read-modify-write
    poke(11'd2, 32'h1122_3344);
    snap = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h1001_000A,
           32'h0000_00AA, lat, rd, er);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_wdata", last_wdata, 32'h11AA_3344);
    chk("sb_wcnt", 32'(wr_cnt - snap), 32'd1);
    chk("sb_mem", mem[2], 32'h11AA_3344);
    chk("sb_rdata", rd, 32'd0);
    poke(11'd1, 32'h1234_5678);
    do_req(1'b1, 2'b01, 1'b1, 32'h1001_0006,
           32'h9999_BEEF, lat, rd, er);
    chk("sh_mem", mem[1], 32'hBEEF_5678);

    // signed and unsigned sub-word loads
    poke(11'd2, 32'h80FF_7F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h1001_000A,
           32'h0, lat, rd, er);
    chk("lb", rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b00, 1'b0, 32'h1001_000B,
           32'h0, lat, rd, er);
    chk("lbu", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b1, 32'h1001_0008,
           32'h0, lat, rd, er);
    chk("lh_lo", rd, 32'h0000_7F01);
    do_req(1'b0, 2'b01, 1'b1, 32'h1001_000A,
           32'h0, lat, rd, er);
    chk("lh_hi", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'b01, 1'b0, 32'h1001_000A,
           32'h0, lat, rd, er);
    chk("lhu_hi", rd, 32'h0000_80FF);

    // last valid word is in range
    poke(11'd2047, 32'h0BAD_F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_1FFC,
           32'h0, lat, rd, er);
    chk("top_err", 32'(er), 32'd0);
    chk("top_data", rd, 32'h0BAD_F00D);

    // error cases
    snap = ena_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0002,
           32'h0, lat, rd, er);
    chk("e_mis_w", 32'(er), 32'd1);
    chk("e_mis_lat", 32'(lat), 32'd2);
    chk("e_mis_rd", rd, 32'd0);
    do_req(1'b1, 2'b01, 1'b0, 32'h1001_0001,
           32'h1234, lat, rd, er);
    chk("e_mis_h", 32'(er), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000_FFFC,
           32'h0, lat, rd, er);
    chk("e_low", 32'(er), 32'd1);
    chk("e_low_rd", rd, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_2000,
           32'h0, lat, rd, er);
    chk("e_oor", 32'(er), 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h1001_0008,
           32'h0, lat, rd, er);
    chk("e_size", 32'(er), 32'd1);
    chk("e_ena", 32'(ena_cnt - snap), 32'd0);

    // reset while a byte store sits in WR
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h1001_0009;
    bus.req_wdata  = 32'h0000_0055;
    wait_ready("rst_wr_to");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    snap  = resp_cnt;
    snap2 = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    chk("rw_inwr", 32'(bus.dm_we), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_ready", 32'(bus.req_ready), 32'd1);
    chk("rw_mem", mem[2], 32'h80FF_7F01);
    chk("rw_resp", 32'(resp_cnt - snap), 32'd0);
    chk("rw_wcnt", 32'(wr_cnt - snap2), 32'd0);

    // back-to-back with req_valid held high
    snap  = resp_cnt;
    snap2 = acc_cnt;
    clash = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b10;
    bus.req_addr   = 32'h1001_0010;
    bus.req_wdata  = 32'hCAFE_F00D;
    wait_ready("b2b0_to");
    @(posedge clk);
    #1;
    bus.req_size   = 2'b00;
    bus.req_addr   = 32'h1001_0011;
    bus.req_wdata  = 32'h0000_0077;
    @(negedge clk);
    wait_ready("b2b1_to");
    @(posedge clk);
    #1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_addr   = 32'h1001_0010;
    @(negedge clk);
    wait_ready("b2b2_to");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_acc", 32'(acc_cnt - snap2), 32'd3);
    chk("b2b_resp", 32'(resp_cnt - snap), 32'd3);
    chk("b2b_data", last_rdata, 32'hCAFE_770D);
    chk("b2b_clash", 32'(clash), 32'd0);

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
